// File: rtl/axi_fft_master.sv
// AXI4 burst master for the FFT bridge: writes N samples as INCR bursts, waits for CALC_END, then reads N results back.
// Latency: AW/AR leave one cycle after the handshake. W and R are combinational pass-throughs. Optional watchdog: AXI_MASTER_TIMEOUT_EN.
// Backpressure: WREADY drives SAMPLE_READY and RESULT_READY drives RREADY. A stalled slave holds the FSM in place.
module axi_fft_master #(
    parameter int DATA_WIDTH  = 32,
    parameter int ID_W_WIDTH  = 2,
    parameter int ID_R_WIDTH  = 2,
    parameter int BURST_LEN   = 16,
    parameter int TXN_ID      = 0,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_START,
    input  logic [11:0]           i_SAMPLES_NUMBER,
    input  logic [15:0]           i_SAMPLE_DATA,
    input  logic                  i_SAMPLE_VALID,
    output logic                  o_SAMPLE_READY,
    input  logic                  i_CALC_END,
    output logic [DATA_WIDTH-1:0] o_RESULT_DATA,
    output logic                  o_RESULT_VALID,
    input  logic                  i_RESULT_READY,
    output logic                  o_BUSY,
    output logic                  o_DONE,
    output logic                  o_ERROR,
    output logic [11:0]           o_AWADDR,
    output logic [7:0]            o_AWLEN,
    output logic [2:0]            o_AWSIZE,
    output logic [1:0]            o_AWBURST,
    output logic [ID_W_WIDTH-1:0] o_AWID,
    output logic                  o_AWVALID,
    input  logic                  i_AWREADY,
    output logic [15:0]           o_WDATA,
    output logic [1:0]            o_WSTRB,
    output logic                  o_WVALID,
    output logic                  o_WLAST,
    input  logic                  i_WREADY,
    input  logic                  i_BVALID,
    input  logic [ID_W_WIDTH-1:0] i_BID,
    output logic                  o_BREADY,
    output logic [11:0]           o_ARADDR,
    output logic [7:0]            o_ARLEN,
    output logic [2:0]            o_ARSIZE,
    output logic [1:0]            o_ARBURST,
    output logic [ID_R_WIDTH-1:0] o_ARID,
    output logic                  o_ARVALID,
    input  logic                  i_ARREADY,
    input  logic [DATA_WIDTH-1:0] i_RDATA,
    input  logic [ID_R_WIDTH-1:0] i_RID,
    input  logic                  i_RVALID,
    input  logic                  i_RLAST,
    output logic                  o_RREADY
);

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_WAIT_CALC, S_AR, S_R, S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [10:0] n_q, n_nxt, idx_q, idx_nxt, idx_inc;
    logic [8:0]  beat_q, beat_nxt;
    logic [7:0]  len_q, len_nxt;
    logic        err_q, err_nxt;
    logic        last_beat, w_hs, r_hs, tmo;
    logic        unused_rid;

    // AxLEN of the next burst starting at sample index i out of n
    function automatic logic [7:0] burst_len(input logic [10:0] n, input logic [10:0] i);
        logic [10:0] rem;
        rem = n - i;
        if (rem > 11'(BURST_LEN))
            return 8'(BURST_LEN - 1);
        return 8'(rem - 11'd1);
    endfunction

    assign idx_inc    = idx_q + 11'd1;
    assign last_beat  = (beat_q == {1'b0, len_q});
    assign w_hs       = (state == S_W) && i_SAMPLE_VALID && i_WREADY;
    assign r_hs       = (state == S_R) && i_RVALID && i_RESULT_READY;
    assign unused_rid = ^i_RID;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q;
    logic          hs;

    always_comb begin
        hs = 1'b1;
        case (state)
            S_AW:    hs = i_AWREADY;
            S_W:     hs = i_SAMPLE_VALID && i_WREADY;
            S_B:     hs = i_BVALID;
            S_AR:    hs = i_ARREADY;
            S_R:     hs = i_RVALID && i_RESULT_READY;
            default: hs = 1'b1;
        endcase
    end

    // counts cycles elapsed since the last handshake (or since entering a waiting state)
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            tmo_q <= '0;
        else if (hs)
            tmo_q <= TW'(1);
        else
            tmo_q <= tmo_q + TW'(1);
    end

    assign tmo = !hs && (tmo_q == TW'(TIMEOUT_CYC - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state  <= S_IDLE;
            n_q    <= '0;
            idx_q  <= '0;
            beat_q <= '0;
            len_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            n_q    <= n_nxt;
            idx_q  <= idx_nxt;
            beat_q <= beat_nxt;
            len_q  <= len_nxt;
            err_q  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        n_nxt     = n_q;
        idx_nxt   = idx_q;
        beat_nxt  = beat_q;
        len_nxt   = len_q;
        err_nxt   = err_q;
        if (tmo) begin
            state_nxt = S_DONE;
            err_nxt   = 1'b1;
        end else begin
            case (state)
                S_IDLE: if (i_START) begin
                    err_nxt = 1'b0;
                    if (i_SAMPLES_NUMBER == 12'd0 || i_SAMPLES_NUMBER > 12'd1024) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        n_nxt     = i_SAMPLES_NUMBER[10:0];
                        idx_nxt   = '0;
                        len_nxt   = burst_len(i_SAMPLES_NUMBER[10:0], 11'd0);
                        state_nxt = S_AW;
                    end
                end
                S_AW: if (i_AWREADY) begin
                    beat_nxt  = '0;
                    state_nxt = S_W;
                end
                S_W: if (w_hs) begin
                    idx_nxt  = idx_inc;
                    beat_nxt = beat_q + 9'd1;
                    if (last_beat)
                        state_nxt = S_B;
                end
                S_B: if (i_BVALID) begin
                    if (i_BID != ID_W_WIDTH'(TXN_ID))
                        err_nxt = 1'b1;
                    if (idx_q < n_q) begin
                        len_nxt   = burst_len(n_q, idx_q);
                        state_nxt = S_AW;
                    end else begin
                        idx_nxt   = '0;
                        state_nxt = S_WAIT_CALC;
                    end
                end
                S_WAIT_CALC: if (i_CALC_END) begin
                    len_nxt   = burst_len(n_q, 11'd0);
                    state_nxt = S_AR;
                end
                S_AR: if (i_ARREADY) begin
                    beat_nxt  = '0;
                    state_nxt = S_R;
                end
                S_R: if (r_hs) begin
                    idx_nxt  = idx_inc;
                    beat_nxt = beat_q + 9'd1;
                    // the beat counter owns burst end; RLAST is only cross-checked
                    if (last_beat != i_RLAST)
                        err_nxt = 1'b1;
                    if (last_beat) begin
                        if (idx_inc < n_q) begin
                            len_nxt   = burst_len(n_q, idx_inc);
                            state_nxt = S_AR;
                        end else begin
                            state_nxt = S_DONE;
                        end
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign o_BUSY    = (state != S_IDLE);
    assign o_DONE    = (state == S_DONE);
    assign o_ERROR   = err_q;

    assign o_AWADDR  = {idx_q, 1'b0};
    assign o_AWLEN   = len_q;
    assign o_AWSIZE  = 3'd1;
    assign o_AWBURST = 2'b01;
    assign o_AWID    = ID_W_WIDTH'(TXN_ID);
    assign o_AWVALID = (state == S_AW);

    assign o_WDATA        = (state == S_W) ? i_SAMPLE_DATA : 16'h0;
    assign o_WSTRB        = (state == S_W) ? 2'b11 : 2'b00;
    assign o_WVALID       = (state == S_W) && i_SAMPLE_VALID;
    assign o_WLAST        = (state == S_W) && last_beat;
    assign o_SAMPLE_READY = (state == S_W) && i_WREADY;

    assign o_BREADY  = (state == S_B);

    assign o_ARADDR  = {idx_q[9:0], 2'b00};
    assign o_ARLEN   = len_q;
    assign o_ARSIZE  = 3'd2;
    assign o_ARBURST = 2'b01;
    assign o_ARID    = ID_R_WIDTH'(TXN_ID);
    assign o_ARVALID = (state == S_AR);

    assign o_RREADY       = (state == S_R) && i_RESULT_READY;
    assign o_RESULT_VALID = (state == S_R) && i_RVALID;
    assign o_RESULT_DATA  = (state == S_R) ? i_RDATA : '0;

endmodule

// File: tb/tb_axi_fft_master.sv
// Randomised bench: slave/source/sink models in one negedge process, a queue scoreboard and a burst-split reference.
module tb_axi_fft_master;
    localparam int BL = 16;
`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int PS = 100;
`else
    localparam int PS = 50;
`endif

    logic        i_clk = 1'b0, i_rstn = 1'b0;
    logic        i_START = 0, i_CALC_END = 0, i_SAMPLE_VALID = 0, i_RESULT_READY = 0;
    logic [11:0] i_SAMPLES_NUMBER = 0;
    logic [15:0] i_SAMPLE_DATA = 0;
    logic        i_AWREADY = 0, i_WREADY = 0, i_BVALID = 0, i_ARREADY = 0, i_RVALID = 0, i_RLAST = 0;
    logic [1:0]  i_BID = 0, i_RID = 0;
    logic [31:0] i_RDATA = 0;
    logic        o_SAMPLE_READY, o_RESULT_VALID, o_BUSY, o_DONE, o_ERROR;
    logic [31:0] o_RESULT_DATA;
    logic [11:0] o_AWADDR, o_ARADDR;
    logic [7:0]  o_AWLEN, o_ARLEN;
    logic [2:0]  o_AWSIZE, o_ARSIZE;
    logic [1:0]  o_AWBURST, o_ARBURST, o_AWID, o_ARID, o_WSTRB;
    logic        o_AWVALID, o_WVALID, o_WLAST, o_BREADY, o_ARVALID, o_RREADY;
    logic [15:0] o_WDATA;

    always #5 i_clk = ~i_clk;

    axi_fft_master #(
`ifdef AXI_MASTER_TIMEOUT_EN
        .TIMEOUT_CYC(8),
`endif
        .BURST_LEN(BL)
    ) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_START(i_START), .i_SAMPLES_NUMBER(i_SAMPLES_NUMBER),
        .i_SAMPLE_DATA(i_SAMPLE_DATA), .i_SAMPLE_VALID(i_SAMPLE_VALID), .o_SAMPLE_READY(o_SAMPLE_READY),
        .i_CALC_END(i_CALC_END), .o_RESULT_DATA(o_RESULT_DATA), .o_RESULT_VALID(o_RESULT_VALID),
        .i_RESULT_READY(i_RESULT_READY), .o_BUSY(o_BUSY), .o_DONE(o_DONE), .o_ERROR(o_ERROR),
        .o_AWADDR(o_AWADDR), .o_AWLEN(o_AWLEN), .o_AWSIZE(o_AWSIZE), .o_AWBURST(o_AWBURST), .o_AWID(o_AWID),
        .o_AWVALID(o_AWVALID), .i_AWREADY(i_AWREADY), .o_WDATA(o_WDATA), .o_WSTRB(o_WSTRB),
        .o_WVALID(o_WVALID), .o_WLAST(o_WLAST), .i_WREADY(i_WREADY), .i_BVALID(i_BVALID), .i_BID(i_BID),
        .o_BREADY(o_BREADY), .o_ARADDR(o_ARADDR), .o_ARLEN(o_ARLEN), .o_ARSIZE(o_ARSIZE),
        .o_ARBURST(o_ARBURST), .o_ARID(o_ARID), .o_ARVALID(o_ARVALID), .i_ARREADY(i_ARREADY),
        .i_RDATA(i_RDATA), .i_RID(i_RID), .i_RVALID(i_RVALID), .i_RLAST(i_RLAST), .o_RREADY(o_RREADY)
    );

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] res_fn(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // model state
    int p_sv = 100, p_wr = 100, p_aw = 100, p_ar = 100, p_b = 100, p_rv = 100, p_rr = 100;
    logic [15:0] src_q[$], wr_q[$];
    bit          wl_q[$];
    logic [11:0] aw_addr_q[$], ar_addr_q[$], rq_addr[$];
    logic [7:0]  aw_len_q[$], ar_len_q[$], rq_len[$];
    logic [31:0] res_q[$];
    logic [19:0] aw_hold_v;
    int src_ptr, r_beat, b_pending, b_seen, bad_bid_at, aw_block_left;
    int done_cnt, done_cyc, wlast_cyc, cyc = 0;
    bit any_valid, aw_wait, b_never, done_err, done_busy;

    task automatic set_p(input int p);
        p_sv = p; p_wr = p; p_aw = p; p_ar = p; p_b = p; p_rv = p; p_rr = p;
    endtask

    task automatic bfm_clear();
        src_q.delete(); wr_q.delete(); wl_q.delete(); res_q.delete();
        aw_addr_q.delete(); aw_len_q.delete(); ar_addr_q.delete(); ar_len_q.delete();
        rq_addr.delete(); rq_len.delete();
        src_ptr = 0; r_beat = 0; b_pending = 0; b_seen = 0; bad_bid_at = -1; aw_block_left = 0;
        done_cnt = 0; done_cyc = 0; wlast_cyc = 0; any_valid = 0; aw_wait = 0; b_never = 0;
        done_err = 0; done_busy = 0;
    endtask

    // slave, sample source and result sink: drive after negedge, observe the values the next posedge will see
    initial begin
        forever begin
            @(negedge i_clk);
            cyc++;
            i_SAMPLE_VALID = (src_ptr < src_q.size()) && ($urandom_range(99) < p_sv);
            i_SAMPLE_DATA  = i_SAMPLE_VALID ? src_q[src_ptr] : 16'h0;
            i_WREADY       = $urandom_range(99) < p_wr;
            i_AWREADY      = (aw_block_left > 0) ? 1'b0 : ($urandom_range(99) < p_aw);
            i_ARREADY      = $urandom_range(99) < p_ar;
            i_BVALID       = (b_pending > 0) && !b_never && ($urandom_range(99) < p_b);
            i_BID          = (i_BVALID && b_seen == bad_bid_at) ? 2'd1 : 2'd0;
            i_RESULT_READY = $urandom_range(99) < p_rr;
            if (rq_addr.size() > 0 && $urandom_range(99) < p_rv) begin
                i_RVALID = 1'b1;
                i_RDATA  = res_fn(int'(rq_addr[0] >> 2) + r_beat);
                i_RLAST  = (r_beat == int'(rq_len[0]));
            end else begin
                i_RVALID = 1'b0; i_RDATA = 32'h0; i_RLAST = 1'b0;
            end
            #1;
            if (o_AWVALID || o_WVALID || o_ARVALID) any_valid = 1;
            if (aw_wait) check("aw_hold", {o_AWVALID, o_AWADDR, o_AWLEN}, {1'b1, aw_hold_v});
            if (o_AWVALID) begin
                if (i_AWREADY) begin
                    aw_addr_q.push_back(o_AWADDR); aw_len_q.push_back(o_AWLEN); aw_wait = 0;
                    check("aw_attr", {o_AWSIZE, o_AWBURST, o_AWID}, {3'd1, 2'b01, 2'd0});
                end else begin
                    aw_wait = 1; aw_hold_v = {o_AWADDR, o_AWLEN};
                    if (aw_block_left > 0) aw_block_left--;
                end
            end
            if (o_WVALID || o_SAMPLE_READY)
                check("w_pass", {o_WVALID, o_SAMPLE_READY}, {i_SAMPLE_VALID, i_WREADY});
            if (o_WVALID && i_WREADY) begin
                wr_q.push_back(o_WDATA); wl_q.push_back(o_WLAST);
                check("w_strb", o_WSTRB, 2'b11);
                if (o_WLAST) begin b_pending++; wlast_cyc = cyc; end
            end
            if (i_SAMPLE_VALID && o_SAMPLE_READY) src_ptr++;
            if (i_BVALID && o_BREADY) begin b_pending--; b_seen++; end
            if (o_ARVALID && i_ARREADY) begin
                ar_addr_q.push_back(o_ARADDR); ar_len_q.push_back(o_ARLEN);
                rq_addr.push_back(o_ARADDR); rq_len.push_back(o_ARLEN);
                check("ar_attr", {o_ARSIZE, o_ARBURST, o_ARID}, {3'd2, 2'b01, 2'd0});
            end
            if (o_RESULT_VALID || o_RREADY)
                check("r_pass", {o_RESULT_VALID, o_RREADY, o_RESULT_DATA}, {i_RVALID, i_RESULT_READY, i_RDATA});
            if (o_RESULT_VALID && i_RESULT_READY) res_q.push_back(o_RESULT_DATA);
            if (i_RVALID && o_RREADY) begin
                if (r_beat == int'(rq_len[0])) begin
                    void'(rq_addr.pop_front()); void'(rq_len.pop_front()); r_beat = 0;
                end else r_beat++;
            end
            if (o_DONE) begin done_cnt++; done_cyc = cyc; done_err = o_ERROR; done_busy = o_BUSY; end
        end
    end

    task automatic pulse_start(input int n, output int sc);
        @(posedge i_clk); #3;
        i_SAMPLES_NUMBER = 12'(n); i_START = 1'b1; sc = cyc + 1;
        @(posedge i_clk); #3;
        i_START = 1'b0; i_SAMPLES_NUMBER = 12'($urandom);
    endtask

    task automatic run_case(input int n, input int bad_b, input int aw_blk, input bit exp_err);
        int nb, sc, calc_at, blen;
        bit legal;
        legal = (n >= 1 && n <= 1024);
        bfm_clear();
        bad_bid_at = bad_b; aw_block_left = aw_blk;
        if (legal) for (int i = 0; i < n; i++) src_q.push_back(16'($urandom));
        nb = legal ? (n + BL - 1) / BL : 0;
        pulse_start(n, sc);
        calc_at = -1;
        for (int k = 0; k < 40000 && done_cnt == 0; k++) begin
            if (k == 1) i_CALC_END = 1'b1;
            if (k == 2) i_CALC_END = 1'b0;
            if (nb > 0 && b_seen >= nb && calc_at < 0) calc_at = k + 4;
            if (k == calc_at) begin
                check("no_early_ar", ar_addr_q.size(), 0);
                i_CALC_END = 1'b1;
            end
            @(posedge i_clk); #3;
        end
        i_CALC_END = 1'b0;
        repeat (3) @(posedge i_clk);
        #3;
        check("done_once", done_cnt, 1);
        check("error", done_err, exp_err);
        check("busy_in_done", done_busy, 1);
        check("idle_after", o_BUSY, 0);
        if (!legal) begin
            check("err_latency", done_cyc, sc + 1);
            check("no_axi", any_valid, 0);
        end else begin
            check("w_count", wr_q.size(), n);
            for (int i = 0; i < n && i < wr_q.size(); i++) begin
                check("w_data", wr_q[i], src_q[i]);
                check("w_last", wl_q[i], ((i % BL) == BL - 1) || (i == n - 1));
            end
            check("aw_count", aw_addr_q.size(), nb);
            check("ar_count", ar_addr_q.size(), nb);
            for (int b = 0; b < nb; b++) begin
                blen = (n - b * BL < BL) ? n - b * BL : BL;
                if (b < aw_addr_q.size())
                    check("aw_burst", {aw_addr_q[b], aw_len_q[b]}, {12'(b * BL * 2), 8'(blen - 1)});
                if (b < ar_addr_q.size())
                    check("ar_burst", {ar_addr_q[b], ar_len_q[b]}, {12'(b * BL * 4), 8'(blen - 1)});
            end
            check("r_count", res_q.size(), n);
            for (int i = 0; i < n && i < res_q.size(); i++)
                check("r_data", res_q[i], res_fn(i));
        end
    endtask

    initial begin
        int n, sc;
        set_p(100);
        bfm_clear();
        repeat (3) @(posedge i_clk);
        #3;
        check("rst_ctrl", {o_AWVALID, o_WVALID, o_WLAST, o_BREADY, o_ARVALID, o_RREADY,
                           o_SAMPLE_READY, o_RESULT_VALID, o_BUSY, o_DONE, o_ERROR}, 0);
        check("rst_regs", {o_AWADDR, o_AWLEN, o_ARADDR, o_ARLEN, o_WDATA}, 0);
        i_rstn = 1'b1;

        run_case(4, -1, 0, 0);
        run_case(40, -1, 0, 0);
        set_p(PS);
        run_case(20, -1, 0, 0);
`ifndef AXI_MASTER_TIMEOUT_EN
        set_p(100);
        run_case(5, -1, 10, 0);
`endif
        run_case(0, -1, 0, 1);
        run_case(1025, -1, 0, 1);
        set_p(PS);
        run_case(37, 1, 0, 1);
        set_p(100);
        run_case(1, -1, 0, 0);

        // reset in the middle of a write burst
        bfm_clear();
        for (int i = 0; i < 40; i++) src_q.push_back(16'($urandom));
        pulse_start(40, sc);
        repeat (6) @(posedge i_clk);
        #3;
        check("mid_in_burst", o_WVALID, 1);
        i_rstn = 1'b0;
        #1;
        check("mid_rst_ctrl", {o_AWVALID, o_WVALID, o_WLAST, o_BREADY, o_ARVALID, o_SAMPLE_READY, o_BUSY, o_DONE}, 0);
        @(posedge i_clk); #3;
        bfm_clear();
        i_rstn = 1'b1;
        run_case(16, -1, 0, 0);

        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(200, 1);
`ifdef AXI_MASTER_TIMEOUT_EN
            set_p(100);
`else
            set_p($urandom_range(100, 40));
`endif
            run_case(n, -1, 0, 0);
        end
        set_p(PS);
        run_case(300, -1, 0, 0);

`ifdef AXI_MASTER_TIMEOUT_EN
        set_p(100);
        bfm_clear();
        b_never = 1;
        for (int i = 0; i < 3; i++) src_q.push_back(16'($urandom));
        pulse_start(3, sc);
        for (int k = 0; k < 200 && done_cnt == 0; k++) begin
            @(posedge i_clk); #3;
        end
        check("tmo_done", done_cnt, 1);
        check("tmo_err", done_err, 1);
        check("tmo_latency", done_cyc, wlast_cyc + 8);
        check("tmo_no_reads", ar_addr_q.size(), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
